// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mul_arbiter_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Magnitude of an operand; two's-complement only when sgn is set.
    // |0x80000000| stays 0x80000000, which is correct when read as unsigned.
    function automatic logic [OP_W-1:0] abs_op(input logic [OP_W-1:0] v, input logic sgn);
        return (sgn && v[OP_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_arbiter_mult.sv
// Combinational 32x32 unsigned multiplier shared by the arbiter.
module mul_arbiter_mult
    import mul_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] product
);

    assign product = {{(PROD_W-OP_W){1'b0}}, a} * {{(PROD_W-OP_W){1'b0}}, b};

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters.
// One operation in flight: IDLE (grant) -> CALC (register product) -> RESP.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int FIRST_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic              req0_signed,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    input  logic              req1_signed,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [PROD_W-1:0] rsp_product,

    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    // Pointer reset value makes FIRST_PRIO win the first tie.
    localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_e              state_q, state_d;
    logic                last_grant_q;
    logic [OP_W-1:0]     a_q, b_q;
    logic                signed_q;
    logic                id_q;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    count_q;

    logic                grant_valid;
    logic                grant_id;
    logic                rsp_hs;
    logic [OP_W-1:0]     mag_a, mag_b;
    logic [PROD_W-1:0]   raw_prod;
    logic                negate;

    // Arbitration: only in IDLE and never while reset is asserted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!rst && state_q == IDLE) begin
            case ({req1_valid, req0_valid})
                2'b01:   begin grant_valid = 1'b1; grant_id = 1'b0;          end
                2'b10:   begin grant_valid = 1'b1; grant_id = 1'b1;          end
                2'b11:   begin grant_valid = 1'b1; grant_id = ~last_grant_q; end
                default: ;
            endcase
        end
    end

    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid &&  grant_id;
    assign rsp_hs     = (state_q == RESP) && rsp_ready;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign handling around the unsigned multiplier; zero is never negated.
    assign mag_a = abs_op(a_q, signed_q);
    assign mag_b = abs_op(b_q, signed_q);

    mul_arbiter_mult u_mult (
        .a       (mag_a),
        .b       (mag_b),
        .product (raw_prod)
    );

    assign negate = signed_q && (a_q[OP_W-1] ^ b_q[OP_W-1]) && (raw_prod != '0);
    assign prod_d = negate ? (~raw_prod + 1'b1) : raw_prod;

    // State, round-robin pointer and owner id.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_RST;
            id_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_valid) begin
                last_grant_q <= grant_id;
                id_q         <= grant_id;
            end
        end
    end

    // Operand capture on grant.
    always_ff @(posedge clk) begin
        // NOTE: operand registers carry no reset; they are always written on grant before being used.
        if (grant_valid) begin
            a_q      <= grant_id ? req1_a      : req0_a;
            b_q      <= grant_id ? req1_b      : req0_b;
            signed_q <= grant_id ? req1_signed : req0_signed;
        end
    end

    // Product register loaded in CALC, held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else if (state_q == CALC) begin
            prod_q <= prod_d;
        end
    end

    // Completed-handshake counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (rsp_hs) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign busy        = (state_q != IDLE);
    assign op_count    = count_q;

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter FIRST_PRIO, default 0: requester that wins the first tie after reset (0 or 1).
REQ-002 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-003 The clock SHALL be clk (input, 1 bit). Reset SHALL be rst (input, 1 bit), synchronous, active-high.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operands accepted this cycle.
REQ-006 req0_a, req0_b  in  32 each  requester 0 operands.
REQ-007 req0_signed  in  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_signed SHALL mirror REQ-004..007 for requester 1.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer takes the result.
REQ-011 rsp_id  out  1  requester that owns the result.
REQ-012 rsp_product  out  64  product.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 op_count  out  CNT_W  number of completed response handshakes, modulo 2^CNT_W.

Function
REQ-015 The block SHALL share one combinational 32x32 unsigned multiplier between two requesters, with at most one operation in flight.
REQ-016 The FSM SHALL have three states: IDLE, CALC and RESP.
  - IDLE->CALC on grant.
  - CALC->RESP unconditionally after 1 cycle.
  - RESP->IDLE on rsp_valid&&rsp_ready.
REQ-017 A grant SHALL occur only in IDLE: reqN_ready=1 for exactly the granted N, and the handshake is reqN_valid&&reqN_ready.
REQ-018 reqN_ready SHALL be combinationally derived from state and valids, and is 0 outside IDLE.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last. The last_grant pointer SHALL reset to !FIRST_PRIO.
REQ-020 With only one requester valid, that requester SHALL be granted regardless of the pointer.
REQ-021 On grant, the block SHALL latch operands, the signed flag and the id.
REQ-022 If the signed flag is set, the multiplier SHALL be fed |a| and |b|, and the product SHALL be negated when sign(a) XOR sign(b).
  - |0x80000000| = 0x80000000 (unsigned).
  - A zero product SHALL never be negated.
REQ-023 In CALC, rsp_product SHALL be registered. Latency: grant cycle T gives rsp_valid=1 from T+2.
REQ-024 In RESP, rsp_valid, rsp_id and rsp_product SHALL stay stable until the rsp handshake.
REQ-025 op_count SHALL increment on each rsp handshake and wrap from all-ones to 0.
REQ-026 The earliest next grant SHALL be the cycle after the rsp handshake, giving a throughput of 1 operation per 3 cycles at best.
REQ-027 A requester that drops valid before grant SHALL lose nothing, since no state is recorded for it.

Reset
REQ-028 rst SHALL dominate all other inputs in the same cycle.
REQ-029 Reset SHALL force state=IDLE, rsp_valid=0, rsp_id=0, rsp_product=0, op_count=0 and last_grant=!FIRST_PRIO.
  - Resulting outputs: busy=0; reqN_ready follows REQ-017 from the next cycle.
REQ-030 Reset during CALC or RESP SHALL discard the in-flight operation, with no response and no count.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=0, CALC=1, RESP=2), the operand width constant (32) and the product width constant (64).
REQ-032 The block SHALL instantiate the team's existing multiplier module (ports a, b, product) as its single sub-module. Sign handling SHALL live in mul_arbiter.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
  - Basic: req0 a=5, b=3, unsigned; grant at T -> rsp_valid at T+2, rsp_id=0, rsp_product=15, op_count=1.
  - Tie: both valid (req0 7x6, req1 9x9), FIRST_PRIO=0 -> req0 served first (42); after that handshake, req1 is granted (81, id=1); ties then alternate.
  - Signed: req1 a=-10 (0xFFFFFFF6), b=20, signed=1 -> rsp_product=0xFFFFFFFFFFFFFF38 (-200). The same operands with signed=0 -> 0x00000013FFFFFF38.
  - Unsigned max: a=0xFFFFFFFF, b=2 -> 0x00000001FFFFFFFE. Signed a=0x80000000, b=0x80000000 -> 0x4000000000000000.
  - Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, reqN_ready=0, busy=1; rsp_ready=1 -> IDLE next cycle.
  - Reset in CALC: rst=1 one cycle after grant -> no rsp_valid, op_count=0, busy=0. A request issued afterwards completes normally.
